// File: rtl/ether_tx_sched_pkg.sv
// Shared encodings and defaults for the Ethernet transmit frame scheduler.
package ether_tx_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_WRITE = 2'd2
    } state_e;

    localparam logic SRC_HOST = 1'b1;
    localparam logic SRC_TREE = 1'b0;

    localparam int LEN_W  = 11;
    localparam int INFL_W = 3;

    localparam logic [LEN_W-1:0] DEF_MIN_LEN = 11'd3;
    localparam logic [LEN_W-1:0] DEF_MAX_LEN = 11'd1500;

endpackage

// File: rtl/ether_tx_sched_if.sv
// Request, frame-info FIFO and status signals between the scheduler and its neighbours.
interface ether_tx_sched_if;
    import ether_tx_sched_pkg::*;

    logic             hostReq;
    logic [LEN_W-1:0] hostLen;
    logic             hostAck;
    logic             treeReq;
    logic [LEN_W-1:0] treeLen;
    logic             treeAck;
    logic             tfFull;
    logic             tfWrEn;
    logic [LEN_W:0]   tfDin;
    logic             TXdataValid;
    logic             lenErr;
    logic [INFL_W-1:0] inflight;

    modport slave (
        input  hostReq, hostLen, treeReq, treeLen, tfFull, TXdataValid,
        output hostAck, treeAck, tfWrEn, tfDin, lenErr, inflight
    );

    modport master (
        output hostReq, hostLen, treeReq, treeLen, tfFull, TXdataValid,
        input  hostAck, treeAck, tfWrEn, tfDin, lenErr, inflight
    );

endinterface

// File: rtl/ether_tx_sched.sv
// Arbitrates host and cache-tree frame requests, checks lengths, writes the
// frame-info FIFO and tracks how many frames are queued or transmitting.
module ether_tx_sched
    import ether_tx_sched_pkg::*;
#(
    parameter logic [LEN_W-1:0] MIN_LEN      = DEF_MIN_LEN,
    parameter logic [LEN_W-1:0] MAX_LEN      = DEF_MAX_LEN,
    parameter int unsigned      MAX_INFLIGHT = 2
) (
    input  logic               ethTXclock,
    input  logic               reset,
    ether_tx_sched_if.slave    bus
);

    localparam logic [INFL_W-1:0] MAX_INF = INFL_W'(MAX_INFLIGHT);

    state_e            state_q, state_d;
    logic              src_q, src_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              rr_q, rr_d;
    logic              ready_q;
    logic              txv_q;
    logic              host_ack_q, host_ack_d;
    logic              tree_ack_q, tree_ack_d;
    logic              wr_en_q, wr_en_d;
    logic [LEN_W:0]    din_q, din_d;
    logic              len_err_q, len_err_d;
    logic [INFL_W-1:0] inflight_q, inflight_d;

    logic host_req_s, tree_req_s, can_grant_s, win_tree_s, fall_s;

    // A request whose Ack is still visible has already been consumed; mask it
    // so the requester's one-cycle reaction to the Ack cannot cause a regrant.
    assign host_req_s  = bus.hostReq & ~host_ack_q;
    assign tree_req_s  = bus.treeReq & ~tree_ack_q;
    assign can_grant_s = ready_q & ~bus.tfFull & (inflight_q < MAX_INF)
                       & (host_req_s | tree_req_s);
    assign win_tree_s  = tree_req_s & (~host_req_s | rr_q);
    assign fall_s      = txv_q & ~bus.TXdataValid;

    // Next-state, grant latch and registered-output decode.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        len_d      = len_q;
        rr_d       = rr_q;
        host_ack_d = 1'b0;
        tree_ack_d = 1'b0;
        wr_en_d    = 1'b0;
        din_d      = din_q;
        len_err_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (can_grant_s) begin
                    state_d = S_CHECK;
                    src_d   = win_tree_s ? SRC_TREE : SRC_HOST;
                    len_d   = win_tree_s ? bus.treeLen : bus.hostLen;
                    rr_d    = win_tree_s ? 1'b0 : 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHECK: begin
                if ((len_q < MIN_LEN) || (len_q > MAX_LEN)) begin
                    len_err_d  = 1'b1;
                    host_ack_d = (src_q == SRC_HOST);
                    tree_ack_d = (src_q == SRC_TREE);
                    state_d    = S_IDLE;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                wr_en_d    = 1'b1;
                din_d      = {src_q, len_q};
                host_ack_d = (src_q == SRC_HOST);
                tree_ack_d = (src_q == SRC_TREE);
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // In-flight count: +1 per FIFO write, -1 per transmitter end-of-frame.
    always_comb begin
        inflight_d = inflight_q;
        if (wr_en_d && !fall_s) begin
            inflight_d = (inflight_q < MAX_INF) ? inflight_q + 3'd1 : inflight_q;
        end else if (fall_s && !wr_en_d) begin
            inflight_d = (inflight_q != 3'd0) ? inflight_q - 3'd1 : inflight_q;
        end else begin
            inflight_d = inflight_q;
        end
    end

    // State and output registers.
    always_ff @(posedge ethTXclock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            src_q      <= SRC_TREE;
            len_q      <= 11'd0;
            rr_q       <= 1'b0;
            ready_q    <= 1'b0;
            txv_q      <= 1'b0;
            host_ack_q <= 1'b0;
            tree_ack_q <= 1'b0;
            wr_en_q    <= 1'b0;
            din_q      <= 12'd0;
            len_err_q  <= 1'b0;
            inflight_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            len_q      <= len_d;
            rr_q       <= rr_d;
            ready_q    <= 1'b1;
            txv_q      <= bus.TXdataValid;
            host_ack_q <= host_ack_d;
            tree_ack_q <= tree_ack_d;
            wr_en_q    <= wr_en_d;
            din_q      <= din_d;
            len_err_q  <= len_err_d;
            inflight_q <= inflight_d;
        end
    end

    assign bus.hostAck  = host_ack_q;
    assign bus.treeAck  = tree_ack_q;
    assign bus.tfWrEn   = wr_en_q;
    assign bus.tfDin    = din_q;
    assign bus.lenErr   = len_err_q;
    assign bus.inflight = inflight_q;

endmodule

// File: tb/tb_ether_tx_sched.sv
// Bench for ether_tx_sched: transaction-timing reference model, directed cases, random traffic.
module tb_ether_tx_sched;
    import ether_tx_sched_pkg::*;

    localparam int MAXI = 2;

    logic ethTXclock = 1'b0;
    logic reset      = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    ether_tx_sched_if bus();

    ether_tx_sched #(.MIN_LEN(11'd3), .MAX_LEN(11'd1500), .MAX_INFLIGHT(MAXI)) dut (
        .ethTXclock (ethTXclock),
        .reset      (reset),
        .bus        (bus)
    );

    always #5 ethTXclock = ~ethTXclock;

    // Reference model: a granted frame finishes one edge later if its length
    // is illegal, two edges later otherwise; nothing else is granted meanwhile.
    bit        m_ready, m_job, m_jtree, m_legal, m_rr, m_ptxv;
    int        m_cyc, m_jcyc;
    bit [10:0] m_jlen;
    bit        e_hack, e_tack, e_wr, e_err;
    bit [11:0] e_din;
    int        e_infl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit hq, tq, inc, fall, wt;
        m_cyc++;
        if (reset) begin
            m_ready = 0; m_job = 0; m_rr = 0; m_ptxv = 0;
            e_hack = 0; e_tack = 0; e_wr = 0; e_err = 0; e_din = 12'd0; e_infl = 0;
            return;
        end
        hq = bus.hostReq && !e_hack;
        tq = bus.treeReq && !e_tack;
        e_hack = 0; e_tack = 0; e_wr = 0; e_err = 0; inc = 0;
        if (m_job) begin
            if (!m_legal && m_cyc == m_jcyc + 1) begin
                e_err = 1; e_hack = !m_jtree; e_tack = m_jtree; m_job = 0;
            end else if (m_legal && m_cyc == m_jcyc + 2) begin
                e_wr = 1; e_din = {!m_jtree, m_jlen};
                e_hack = !m_jtree; e_tack = m_jtree; inc = 1; m_job = 0;
            end
        end else if (m_ready && !bus.tfFull && e_infl < MAXI && (hq || tq)) begin
            wt      = tq && (!hq || m_rr);
            m_job   = 1;
            m_jcyc  = m_cyc;
            m_jtree = wt;
            m_jlen  = wt ? bus.treeLen : bus.hostLen;
            m_legal = (m_jlen >= 3) && (m_jlen <= 1500);
            m_rr    = !wt;
        end
        fall   = m_ptxv && !bus.TXdataValid;
        m_ptxv = bus.TXdataValid;
        if (inc && !fall) e_infl = (e_infl + 1 > MAXI) ? MAXI : e_infl + 1;
        else if (fall && !inc && e_infl > 0) e_infl = e_infl - 1;
        m_ready = 1;
    endtask

    task automatic tick();
        @(posedge ethTXclock);
        model_step();
        #1;
        chk("hostAck",  bus.hostAck,  e_hack);
        chk("treeAck",  bus.treeAck,  e_tack);
        chk("tfWrEn",   bus.tfWrEn,   e_wr);
        chk("tfDin",    bus.tfDin,    e_din);
        chk("lenErr",   bus.lenErr,   e_err);
        chk("inflight", bus.inflight, e_infl);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        bus.hostReq = 1'b0; bus.hostLen = 11'd0;
        bus.treeReq = 1'b0; bus.treeLen = 11'd0;
        bus.tfFull = 1'b0; bus.TXdataValid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_wr(input string name, input logic [11:0] exp_din, input int bound);
        bit seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            tick();
            if (bus.tfWrEn) seen = 1;
        end
        chk({name, " write seen"}, seen, 1);
        if (seen) chk({name, " tfDin"}, bus.tfDin, exp_din);
    endtask

    function automatic logic [10:0] rand_len();
        int unsigned r = $urandom_range(0, 9);
        case (r)
            0: return 11'($urandom_range(0, 2));
            1: return 11'($urandom_range(1501, 2047));
            2: return 11'd3;
            3: return 11'd1500;
            default: return 11'($urandom_range(3, 1500));
        endcase
    endfunction

    initial begin
        int wr_cnt;
        bus.hostReq = 1'b0; bus.hostLen = 11'd0;
        bus.treeReq = 1'b0; bus.treeLen = 11'd0;
        bus.tfFull = 1'b0; bus.TXdataValid = 1'b0;

        // Reset state and host-only 64-byte frame.
        apply_reset();
        chk("reset inflight", bus.inflight, 0);
        chk("reset tfDin", bus.tfDin, 12'h000);
        bus.hostReq = 1'b1; bus.hostLen = 11'd64;
        tick(); tick(); tick();
        chk("host64 early write", bus.tfWrEn, 0);
        tick();
        chk("host64 tfWrEn", bus.tfWrEn, 1);
        chk("host64 tfDin", bus.tfDin, 12'h840);
        chk("host64 hostAck", bus.hostAck, 1);
        chk("host64 inflight", bus.inflight, 1);
        bus.hostReq = 1'b0;
        tick(); tick();

        // Both requesters held: host first after reset, then tree.
        apply_reset();
        bus.hostReq = 1'b1; bus.hostLen = 11'd100;
        bus.treeReq = 1'b1; bus.treeLen = 11'd200;
        wait_wr("both first", 12'h864, 6);
        wait_wr("both second", 12'h0C8, 6);
        chk("both inflight", bus.inflight, 2);
        bus.hostReq = 1'b0; bus.treeReq = 1'b0;
        tick(); tick();

        // Illegal tree lengths: 2 then 1501.
        apply_reset();
        bus.treeReq = 1'b1; bus.treeLen = 11'd2;
        tick(); tick(); tick();
        chk("len2 lenErr", bus.lenErr, 1);
        chk("len2 treeAck", bus.treeAck, 1);
        chk("len2 tfWrEn", bus.tfWrEn, 0);
        chk("len2 inflight", bus.inflight, 0);
        bus.treeLen = 11'd1501;
        tick(); tick(); tick();
        chk("len1501 lenErr", bus.lenErr, 1);
        chk("len1501 treeAck", bus.treeAck, 1);
        chk("len1501 tfWrEn", bus.tfWrEn, 0);
        bus.treeReq = 1'b0;
        tick();

        // In-flight limit: third host frame waits for an end-of-frame.
        apply_reset();
        bus.hostReq = 1'b1; bus.hostLen = 11'd64;
        wait_wr("limit f1", 12'h840, 6);
        wait_wr("limit f2", 12'h840, 6);
        wr_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.tfWrEn) wr_cnt++;
        end
        chk("limit held writes", wr_cnt, 0);
        chk("limit inflight", bus.inflight, 2);
        bus.TXdataValid = 1'b1;
        tick();
        bus.TXdataValid = 1'b0;
        wait_wr("limit f3", 12'h840, 6);
        chk("limit inflight after", bus.inflight, 2);
        bus.hostReq = 1'b0;
        tick(); tick();

        // FIFO full blocks grants; release gives a write two edges after grant.
        apply_reset();
        bus.tfFull = 1'b1;
        bus.hostReq = 1'b1; bus.hostLen = 11'd100;
        wr_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.tfWrEn) wr_cnt++;
        end
        chk("full no write", wr_cnt, 0);
        bus.tfFull = 1'b0;
        tick(); tick();
        chk("full release early", bus.tfWrEn, 0);
        tick();
        chk("full release tfWrEn", bus.tfWrEn, 1);
        chk("full release tfDin", bus.tfDin, 12'h864);
        bus.hostReq = 1'b0;
        tick(); tick();

        // Reset while the grant is about to be written discards it.
        bus.hostReq = 1'b1; bus.hostLen = 11'd200;
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("rst write tfWrEn", bus.tfWrEn, 0);
        chk("rst write hostAck", bus.hostAck, 0);
        chk("rst write inflight", bus.inflight, 0);
        tick();
        reset = 1'b0;
        wait_wr("rerequest", 12'h8C8, 6);
        bus.hostReq = 1'b0;
        tick(); tick();

        // Random traffic against the model.
        apply_reset();
        for (int c = 0; c < 4000; c++) begin
            if (bus.hostReq) begin
                if (bus.hostAck) begin
                    if ($urandom_range(0, 1) == 0) bus.hostLen = rand_len();
                    else bus.hostReq = 1'b0;
                end else if ($urandom_range(0, 39) == 0) begin
                    bus.hostReq = 1'b0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                bus.hostReq = 1'b1; bus.hostLen = rand_len();
            end
            if (bus.treeReq) begin
                if (bus.treeAck) begin
                    if ($urandom_range(0, 1) == 0) bus.treeLen = rand_len();
                    else bus.treeReq = 1'b0;
                end else if ($urandom_range(0, 39) == 0) begin
                    bus.treeReq = 1'b0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                bus.treeReq = 1'b1; bus.treeLen = rand_len();
            end
            bus.tfFull = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) bus.TXdataValid = ~bus.TXdataValid;
            if ($urandom_range(0, 499) == 0) apply_reset();
            else tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ether_tx_sched.md
ETHER_TX_SCHED -- requirements
Module: ether_tx_sched

Interface
REQ-001 Parameter MIN_LEN, default 11'd3, smallest legal payload byte count.
REQ-002 Parameter MAX_LEN, default 11'd1500, largest legal payload byte count.
REQ-003 Parameter MAX_INFLIGHT, default 2, frames queued or transmitting at once, range 1..7.
REQ-004 ethTXclock  in  1   clock; reset, asynchronous, active-high; clock ethTXclock.
REQ-005 reset  in  1   asynchronous active-high reset.
REQ-006 hostReq  in  1   host path has a frame ready; held until hostAck.
REQ-007 hostLen  in  11  host frame payload bytes; stable while hostReq high.
REQ-008 hostAck  out  1  one-cycle pulse: host request consumed (queued or rejected).
REQ-009 treeReq  in  1   cache-tree path has a frame ready; held until treeAck.
REQ-010 treeLen  in  11  tree frame payload bytes; stable while treeReq high.
REQ-011 treeAck  out  1  one-cycle pulse: tree request consumed.
REQ-012 tfFull  in  1    transmitter frame-info FIFO full.
REQ-013 tfWrEn  out  1   frame-info FIFO write strobe, one cycle per frame.
REQ-014 tfDin  out  12   frame-info word: [11]=1 host, 0 tree; [10:0]=payload bytes.
REQ-015 TXdataValid  in  1  transmitter byte-valid; falling edge = frame finished.
REQ-016 lenErr  out  1   one-cycle pulse: granted request had illegal length, dropped.
REQ-017 inflight  out  3  current frames queued or transmitting.

Function
REQ-018 States: S_IDLE, S_CHECK, S_WRITE; every output registered.
REQ-019 S_IDLE: transition to S_CHECK when (hostReq or treeReq) and !tfFull and inflight < MAX_INFLIGHT; latch winner source and length.
REQ-020 Arbitration: if one requester is active, it wins; if both are active, the rrPtr side wins (rrPtr=0 host, 1 tree).
REQ-021 rrPtr set to the loser side after every grant, including rejected grants; reset value 0.
REQ-022 S_CHECK: length < MIN_LEN or > MAX_LEN -> lenErr=1 and winner Ack=1 next cycle, return to S_IDLE, no FIFO write.
REQ-023 S_CHECK legal length -> S_WRITE.
REQ-024 S_WRITE: tfWrEn=1, tfDin={src,len}, winner Ack=1 same cycle; return to S_IDLE.
REQ-025 Latency: request sampled in S_IDLE at cycle N -> tfWrEn and Ack asserted at cycle N+2; next grant no earlier than N+3.
REQ-026 tfFull rising during S_CHECK/S_WRITE does not abort; the write still occurs (FIFO guarantees one-slot headroom).
REQ-027 inflight increments on tfWrEn, decrements on TXdataValid 1->0 (one-cycle delayed sample); simultaneous -> unchanged.
REQ-028 inflight saturates at 0 on a spurious falling edge; never exceeds MAX_INFLIGHT.
REQ-029 Requester deasserting Req before Ack: the latched grant still completes and the Ack still pulses.
REQ-030 hostAck and treeAck never high in the same cycle; lenErr only coincident with an Ack.

Reset
REQ-031 Reset forces S_IDLE; hostAck, treeAck, tfWrEn, lenErr = 0; tfDin = 12'd0; inflight = 0; rrPtr = 0; TXdataValid edge register = 0.
REQ-032 Reset mid-S_CHECK/S_WRITE discards the grant with no write and no Ack; the requester re-requests.
REQ-033 First grant possible in the second rising edge after reset deasserts.

Structure
REQ-034 Shared package holds state encodings, source-bit values (SRC_HOST=1, SRC_TREE=0) and the default MIN_LEN/MAX_LEN.
REQ-035 Single module; no sub-module; arbitration logic is inline.

Verification
REQ-036 Host-only, hostLen=64 -> tfWrEn two cycles later, tfDin=12'h840, hostAck same cycle, inflight=1.
REQ-037 Both requests held, lengths 100/200, after reset -> host tfDin=12'h864 first, then tree 12'h0C8; rrPtr alternates.
REQ-038 treeLen=2 -> lenErr and treeAck pulse, no tfWrEn, inflight unchanged; treeLen=1501 behaves the same.
REQ-039 MAX_INFLIGHT=2, three host frames -> third held until a TXdataValid falling edge, then written.
REQ-040 tfFull=1 with pending request -> no grant; release -> write at +2 cycles; reset asserted in S_WRITE -> no write or Ack.
